output_gain_ramp: RTL

OUTPUT_GAIN_RAMP -- requirements
Module: output_gain_ramp

---
 rtl/output_gain_ramp.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/output_gain_ramp.sv
// Output gain stage: per-frame gain ramp toward a (possibly muted) target,
// followed by a 3-stage multiply / shift / saturate pipeline on every I2S word.
module output_gain_ramp #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8,
  parameter int STEP   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     l_r_clk,
  input  logic signed [DATA_W-1:0] audio_in,
  input  logic        [GAIN_W-1:0] gain_target,
  input  logic                     mute,
  output logic signed [DATA_W-1:0] audio_out,
  output logic                     sample_valid,
  output logic                     ramping,
  output logic                     clip
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int FRAC   = 7;
  localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);
  localparam logic signed [PROD_W-1:0] SAT_MAX =
    {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic                     lr_q_reg;
  logic                     edge_det;
  logic                     rise_det;
  logic        [GAIN_W-1:0] tgt_now;
  logic        [GAIN_W-1:0] gain_cur_reg, gain_next;
  logic        [GAIN_W-1:0] gain_diff;

  logic                     s1_valid_reg;
  logic signed [DATA_W-1:0] s1_sample_reg;
  logic        [GAIN_W-1:0] s1_gain_reg;
  logic                     s2_valid_reg;
  logic signed [PROD_W-1:0] s2_prod_reg;
  logic signed [PROD_W-1:0] prod_full;
  logic signed [PROD_W-1:0] prod_shift;
  logic signed [DATA_W-1:0] sat_val;
  logic                     sat_clip;

  assign edge_det = l_r_clk ^ lr_q_reg;
  assign rise_det = edge_det & l_r_clk;
  assign tgt_now  = mute ? '0 : gain_target;

  // Step toward the target, clamping the last step so the gain never overshoots.
  always_comb begin
    gain_next = gain_cur_reg;
    gain_diff = '0;
    if (rise_det) begin
      if (gain_cur_reg < tgt_now) begin
        gain_diff = tgt_now - gain_cur_reg;
        gain_next = gain_cur_reg + ((gain_diff < STEP_G) ? gain_diff : STEP_G);
      end else if (gain_cur_reg > tgt_now) begin
        gain_diff = gain_cur_reg - tgt_now;
        gain_next = gain_cur_reg - ((gain_diff < STEP_G) ? gain_diff : STEP_G);
      end
    end
  end

  // State reflects the relation between the freshly updated gain and target.
  always_comb begin
    state_next = state_reg;
    if (rise_det) begin
      if (gain_next < tgt_now)
        state_next = RAMP_UP;
      else if (gain_next > tgt_now)
        state_next = RAMP_DOWN;
      else if (gain_next == '0)
        state_next = MUTED;
      else
        state_next = HOLD;
    end
  end

  assign ramping = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);

  // Unsigned gain is zero-extended so the signed multiply keeps Q1.7 semantics.
  always_comb begin
    prod_full  = PROD_W'(s1_sample_reg) * $signed({1'b0, s1_gain_reg});
    prod_shift = prod_full >>> FRAC;
  end

  always_comb begin
    sat_val  = s2_prod_reg[DATA_W-1:0];
    sat_clip = 1'b0;
    if (s2_prod_reg > SAT_MAX) begin
      sat_val  = SAT_MAX[DATA_W-1:0];
      sat_clip = 1'b1;
    end else if (s2_prod_reg < SAT_MIN) begin
      sat_val  = SAT_MIN[DATA_W-1:0];
      sat_clip = 1'b1;
    end
  end

  // Every word edge enters the pipeline; one sample per clk is sustainable,
  // so closely spaced edges are simply carried through in order.
  always_ff @(posedge clk) begin
    if (reset) begin
      lr_q_reg      <= l_r_clk;
      gain_cur_reg  <= '0;
      state_reg     <= MUTED;
      s1_valid_reg  <= 1'b0;
      s1_sample_reg <= '0;
      s1_gain_reg   <= '0;
      s2_valid_reg  <= 1'b0;
      s2_prod_reg   <= '0;
      audio_out     <= '0;
      clip          <= 1'b0;
      sample_valid  <= 1'b0;
    end else begin
      lr_q_reg      <= l_r_clk;
      gain_cur_reg  <= gain_next;
      state_reg     <= state_next;
      s1_valid_reg  <= edge_det;
      s2_valid_reg  <= s1_valid_reg;
      sample_valid  <= s2_valid_reg;
      if (edge_det) begin
        s1_sample_reg <= audio_in;
        s1_gain_reg   <= gain_cur_reg;
      end
      if (s1_valid_reg)
        s2_prod_reg <= prod_shift;
      if (s2_valid_reg) begin
        audio_out <= sat_val;
        clip      <= sat_clip;
      end
    end
  end

endmodule
